score_keeper: RTL and testbench
===============================

SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter MAX_OVERS, default 20, overs per innings (1..31).
REQ-002 Parameter MAX_WICKETS, default 10, wickets ending an innings (1..15).
REQ-003 Parameter BALLS_PER_OVER, default 6, legal balls per over (1..7).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 ball_valid  input  1  one-cycle pulse marking one delivery event.
REQ-007 ball_runs  input  3  runs scored off the bat, legal range 0..6.
REQ-008 ball_wicket  input  1  delivery took a wicket; qualified by ball_valid.
REQ-009 ball_extra  input  1  wide or no-ball; qualified by ball_valid.
REQ-010 next_inning  input  1  pulse starting innings 2 from the break.
REQ-011 new_game  input  1  pulse restarting the match.
REQ-012 binaryruns  output  8  current innings runs, saturating.
REQ-013 binarywickets  output  4  current innings wickets.
REQ-014 overs  output  5  completed overs in current innings.
REQ-015 balls  output  3  legal balls in current over.
REQ-016 inning  output  1  0 = innings 1, 1 = innings 2.
REQ-017 inningOver  output  1  innings 1 finished, awaiting next_inning.
REQ-018 gameOver  output  1  match decided; outputs frozen.
REQ-019 winner  output  1  0 = team 1, 1 = team 2; valid while gameOver.
REQ-020 tie  output  1  scores level at end of innings 2; valid while gameOver.

Function
REQ-021 Four states SHALL exist: INN1, BREAK, INN2, DONE; all outputs registered.
REQ-022 A ball_valid event in INN1/INN2 SHALL update counters at the sampling edge (outputs visible one cycle after the pulse).
REQ-023 Runs added SHALL be ball_runs, plus 1 when ball_extra=1; binaryruns SHALL saturate at 255.
REQ-024 ball_runs = 7 SHALL cause the whole event to be ignored.
REQ-025 ball_wicket=1 SHALL increment binarywickets, together with any runs of the same event, extra or not.
REQ-026 A legal ball (ball_extra=0) SHALL increment balls; at BALLS_PER_OVER it SHALL wrap to 0 and increment overs in the same edge.
REQ-027 INN1 SHALL move to BREAK on the edge where binarywickets reaches MAX_WICKETS or overs reaches MAX_OVERS; inningOver SHALL be 1 from that edge.
REQ-028 On BREAK entry, innings-1 runs SHALL be latched as the target; counters hold their final values.
REQ-029 next_inning in BREAK SHALL clear runs/wickets/overs/balls, set inning=1, clear inningOver, enter INN2; next_inning in other states SHALL be ignored.
REQ-030 In INN2, runs strictly greater than target SHALL enter DONE on that edge, winner=1, tie=0.
REQ-031 In INN2, wicket or over limit reached with runs not greater than target SHALL enter DONE; runs < target gives winner=0, tie=0; runs = target gives winner=0, tie=1.
REQ-032 When the target is exceeded on the same event that reaches a limit, the win of REQ-030 SHALL take precedence.
REQ-033 ball_valid in BREAK or DONE SHALL be ignored; DONE SHALL hold all outputs until new_game or reset.
REQ-034 new_game in any state SHALL perform the reset action of REQ-036 synchronously and take priority over a coincident ball_valid or next_inning.
REQ-035 winner and tie SHALL be 0 whenever gameOver=0.

Reset
REQ-036 reset_n low SHALL asynchronously force state INN1, all counters, target and every output to 0.
REQ-037 Reset asserted mid-innings or in DONE SHALL discard all match state; first event after release is counted as innings 1 ball 1.

Verification
REQ-038 After reset, event runs=4, extra=0 -> next cycle binaryruns=4, balls=1, overs=0.
REQ-039 Six legal dots then one wide with runs=0 -> overs=1, balls=0, binaryruns=1.
REQ-040 Ten wicket events in INN1 -> inningOver=1, state BREAK; further ball_valid leaves all outputs unchanged.
REQ-041 Innings 1 ends at 150 runs; in INN2 reach 151 with 3 wickets -> gameOver=1, winner=1, tie=0 on that edge.
REQ-042 Innings 1 at 150, innings 2 all out at 150 -> gameOver=1, winner=0, tie=1; at 120 -> winner=0, tie=0.
REQ-043 Drive 260 runs in INN1 -> binaryruns holds 255; reset_n pulsed low mid-INN2 -> all outputs 0 immediately, inning=0.

Source files
------------

// File: rtl/score_keeper_if.sv
// Delivery-event bundle: one ball_valid pulse qualifies runs, wicket and extra.
interface score_keeper_if;
    logic       ball_valid;
    logic [2:0] ball_runs;
    logic       ball_wicket;
    logic       ball_extra;

    modport master (output ball_valid, ball_runs, ball_wicket, ball_extra);
    modport slave  (input  ball_valid, ball_runs, ball_wicket, ball_extra);
endinterface

// File: rtl/score_keeper.sv
// Two-innings limited-overs scoreboard: counts runs, wickets, overs and balls,
// latches the innings-1 target and decides the match in innings 2.
module score_keeper #(
    parameter int MAX_OVERS      = 20,
    parameter int MAX_WICKETS    = 10,
    parameter int BALLS_PER_OVER = 6
) (
    input  logic                 clk,
    input  logic                 reset_n,
    score_keeper_if.slave        ball,
    input  logic                 next_inning,
    input  logic                 new_game,
    output logic [7:0]           binaryruns,
    output logic [3:0]           binarywickets,
    output logic [4:0]           overs,
    output logic [2:0]           balls,
    output logic                 inning,
    output logic                 inningOver,
    output logic                 gameOver,
    output logic                 winner,
    output logic                 tie
);
    typedef enum logic [1:0] {INN1, BREAK, INN2, DONE} state_t;

    localparam logic [2:0] LAST_BALL = 3'(BALLS_PER_OVER - 1);
    localparam logic [3:0] WKT_LIMIT = 4'(MAX_WICKETS);
    localparam logic [4:0] OVR_LIMIT = 5'(MAX_OVERS);

    state_t     state, state_nx;
    logic [7:0] target, target_nx;
    logic [7:0] runs_nx;
    logic [3:0] wickets_nx;
    logic [4:0] overs_nx;
    logic [2:0] balls_nx;
    logic       inning_nx, inning_over_nx, game_over_nx, winner_nx, tie_nx;

    logic [8:0] run_sum;
    logic [7:0] ev_runs;
    logic [3:0] ev_wickets;
    logic [4:0] ev_overs;
    logic [2:0] ev_balls;
    logic       ev_ok, limit;

    // Post-delivery counter values, used only when the event is accepted.
    always_comb begin
        run_sum    = {1'b0, binaryruns} + 9'(ball.ball_runs) + 9'(ball.ball_extra);
        ev_runs    = run_sum[8] ? 8'hFF : run_sum[7:0];
        ev_wickets = binarywickets + 4'(ball.ball_wicket);
        ev_overs   = overs;
        ev_balls   = balls;
        if (!ball.ball_extra) begin
            if (balls == LAST_BALL) begin
                ev_balls = '0;
                ev_overs = overs + 5'd1;
            end else begin
                ev_balls = balls + 3'd1;
            end
        end
        ev_ok = ball.ball_valid && (ball.ball_runs != 3'd7);
        limit = (ev_wickets == WKT_LIMIT) || (ev_overs == OVR_LIMIT);
    end

    always_comb begin
        state_nx       = state;
        target_nx      = target;
        runs_nx        = binaryruns;
        wickets_nx     = binarywickets;
        overs_nx       = overs;
        balls_nx       = balls;
        inning_nx      = inning;
        inning_over_nx = inningOver;
        game_over_nx   = gameOver;
        winner_nx      = winner;
        tie_nx         = tie;

        if (new_game) begin
            state_nx       = INN1;
            target_nx      = '0;
            runs_nx        = '0;
            wickets_nx     = '0;
            overs_nx       = '0;
            balls_nx       = '0;
            inning_nx      = 1'b0;
            inning_over_nx = 1'b0;
            game_over_nx   = 1'b0;
            winner_nx      = 1'b0;
            tie_nx         = 1'b0;
        end else begin
            unique case (state)
                INN1: begin
                    if (ev_ok) begin
                        runs_nx    = ev_runs;
                        wickets_nx = ev_wickets;
                        overs_nx   = ev_overs;
                        balls_nx   = ev_balls;
                        if (limit) begin
                            state_nx       = BREAK;
                            inning_over_nx = 1'b1;
                            target_nx      = ev_runs;
                        end
                    end
                end
                BREAK: begin
                    if (next_inning) begin
                        state_nx       = INN2;
                        runs_nx        = '0;
                        wickets_nx     = '0;
                        overs_nx       = '0;
                        balls_nx       = '0;
                        inning_nx      = 1'b1;
                        inning_over_nx = 1'b0;
                    end
                end
                INN2: begin
                    if (ev_ok) begin
                        runs_nx    = ev_runs;
                        wickets_nx = ev_wickets;
                        overs_nx   = ev_overs;
                        balls_nx   = ev_balls;
                        // Passing the target wins even if the same ball hits a limit.
                        if (ev_runs > target) begin
                            state_nx     = DONE;
                            game_over_nx = 1'b1;
                            winner_nx    = 1'b1;
                        end else if (limit) begin
                            state_nx     = DONE;
                            game_over_nx = 1'b1;
                            tie_nx       = (ev_runs == target);
                        end
                    end
                end
                DONE: ;
                default: state_nx = INN1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= INN1;
            target        <= '0;
            binaryruns    <= '0;
            binarywickets <= '0;
            overs         <= '0;
            balls         <= '0;
            inning        <= 1'b0;
            inningOver    <= 1'b0;
            gameOver      <= 1'b0;
            winner        <= 1'b0;
            tie           <= 1'b0;
        end else begin
            state         <= state_nx;
            target        <= target_nx;
            binaryruns    <= runs_nx;
            binarywickets <= wickets_nx;
            overs         <= overs_nx;
            balls         <= balls_nx;
            inning        <= inning_nx;
            inningOver    <= inning_over_nx;
            gameOver      <= game_over_nx;
            winner        <= winner_nx;
            tie           <= tie_nx;
        end
    end
endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: directed vector table, then model-driven match
// sequences whose expectations flow through a scoreboard queue.
module tb_score_keeper;
    localparam int MW  = 10;
    localparam int MO  = 20;
    localparam int BPO = 6;

    typedef struct packed {
        logic [7:0] runs;
        logic [3:0] wk;
        logic [4:0] ov;
        logic [2:0] bl;
        logic       inn;
        logic       io;
        logic       go;
        logic       win;
        logic       tie;
    } exp_t;

    typedef struct {
        logic       v;
        logic [2:0] r;
        logic       w;
        logic       e;
        logic       ni;
        logic       ng;
        exp_t       x;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       next_inning = 1'b0;
    logic       new_game = 1'b0;
    logic [7:0] binaryruns;
    logic [3:0] binarywickets;
    logic [4:0] overs;
    logic [2:0] balls;
    logic       inning, inningOver, gameOver, winner, tie;
    exp_t       act;

    int tests = 0;
    int fails = 0;
    exp_t q[$];

    // Reference model state: st 0=INN1 1=BREAK 2=INN2 3=DONE
    int m_runs, m_wk, m_ov, m_bl, m_tgt, m_st, m_inn, m_io, m_go, m_win, m_tie;

    score_keeper_if bif ();

    score_keeper #(.MAX_OVERS(MO), .MAX_WICKETS(MW), .BALLS_PER_OVER(BPO)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ball         (bif.slave),
        .next_inning  (next_inning),
        .new_game     (new_game),
        .binaryruns   (binaryruns),
        .binarywickets(binarywickets),
        .overs        (overs),
        .balls        (balls),
        .inning       (inning),
        .inningOver   (inningOver),
        .gameOver     (gameOver),
        .winner       (winner),
        .tie          (tie)
    );

    always #5 clk = ~clk;

    always_comb act = {binaryruns, binarywickets, overs, balls, inning, inningOver, gameOver, winner, tie};

    function automatic exp_t mkexp(int r, int w, int o, int b, int inn, int io, int go, int win, int t);
        exp_t x;
        x.runs = 8'(r); x.wk = 4'(w); x.ov = 5'(o); x.bl = 3'(b);
        x.inn = 1'(inn); x.io = 1'(io); x.go = 1'(go); x.win = 1'(win); x.tie = 1'(t);
        return x;
    endfunction

    function automatic vec_t mk(int v, int r, int w, int e, int ni, int ng, exp_t x);
        vec_t t;
        t.v = 1'(v); t.r = 3'(r); t.w = 1'(w); t.e = 1'(e); t.ni = 1'(ni); t.ng = 1'(ng);
        t.x = x;
        return t;
    endfunction

    task automatic model_reset();
        m_runs = 0; m_wk = 0; m_ov = 0; m_bl = 0; m_tgt = 0; m_st = 0;
        m_inn = 0; m_io = 0; m_go = 0; m_win = 0; m_tie = 0;
    endtask

    function automatic exp_t model_exp();
        return mkexp(m_runs, m_wk, m_ov, m_bl, m_inn, m_io, m_go, m_win, m_tie);
    endfunction

    task automatic model_step(int v, int r, int w, int e, int ni, int ng);
        bit lim;
        if (ng != 0) begin
            model_reset();
        end else if ((m_st == 0 || m_st == 2) && v != 0 && r != 7) begin
            m_runs = m_runs + r + e;
            if (m_runs > 255) m_runs = 255;
            m_wk = m_wk + w;
            if (e == 0) begin
                m_bl++;
                if (m_bl == BPO) begin
                    m_bl = 0;
                    m_ov++;
                end
            end
            lim = (m_wk >= MW) || (m_ov >= MO);
            if (m_st == 0) begin
                if (lim) begin
                    m_st = 1; m_io = 1; m_tgt = m_runs;
                end
            end else if (m_runs > m_tgt) begin
                m_st = 3; m_go = 1; m_win = 1;
            end else if (lim) begin
                m_st = 3; m_go = 1; m_tie = (m_runs == m_tgt) ? 1 : 0;
            end
        end else if (m_st == 1 && ni != 0) begin
            m_runs = 0; m_wk = 0; m_ov = 0; m_bl = 0;
            m_inn = 1; m_io = 0; m_st = 2;
        end
    endtask

    task automatic drive(int v, int r, int w, int e, int ni, int ng);
        bif.ball_valid  = 1'(v);
        bif.ball_runs   = 3'(r);
        bif.ball_wicket = 1'(w);
        bif.ball_extra  = 1'(e);
        next_inning     = 1'(ni);
        new_game        = 1'(ng);
        model_step(v, r, w, e, ni, ng);
    endtask

    task automatic check(input string name);
        exp_t x;
        @(posedge clk);
        #1;
        tests++;
        if (q.size() == 0) begin
            fails++;
            $display("FAIL %s: scoreboard empty, actual %h", name, act);
        end else begin
            x = q.pop_front();
            if (act !== x) begin
                fails++;
                $display("FAIL %s: actual %h required %h", name, act, x);
            end
        end
        @(negedge clk);
        bif.ball_valid = 1'b0; bif.ball_wicket = 1'b0; bif.ball_extra = 1'b0;
        bif.ball_runs = 3'd0; next_inning = 1'b0; new_game = 1'b0;
    endtask

    task automatic step(int v, int r, int w, int e, int ni, int ng, input string name);
        drive(v, r, w, e, ni, ng);
        q.push_back(model_exp());
        check(name);
    endtask

    task automatic ev(int r, int w, int e, input string name);
        step(1, r, w, e, 0, 0, name);
    endtask

    task automatic expect_now(input string name, input exp_t x);
        tests++;
        if (act !== x) begin
            fails++;
            $display("FAIL %s: actual %h required %h", name, act, x);
        end
    endtask

    task automatic innings1_150();
        step(0, 0, 0, 0, 0, 1, "new_game");
        repeat (25) ev(6, 0, 0, "inn1_six");
        repeat (10) ev(0, 1, 0, "inn1_wkt");
        step(0, 0, 0, 0, 1, 0, "next_inning");
    endtask

    vec_t tbl[17];

    initial begin
        bif.ball_valid = 1'b0; bif.ball_runs = 3'd0; bif.ball_wicket = 1'b0; bif.ball_extra = 1'b0;
        model_reset();

        #2 reset_n = 1'b0;
        #1 expect_now("reset_state", '0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        tbl[0]  = mk(0, 0, 0, 0, 0, 1, mkexp(0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl[1]  = mk(1, 4, 0, 0, 0, 0, mkexp(4, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl[2]  = mk(0, 0, 0, 0, 0, 1, mkexp(0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl[3]  = mk(1, 0, 0, 0, 0, 0, mkexp(0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl[4]  = mk(1, 0, 0, 0, 0, 0, mkexp(0, 0, 0, 2, 0, 0, 0, 0, 0));
        tbl[5]  = mk(1, 0, 0, 0, 0, 0, mkexp(0, 0, 0, 3, 0, 0, 0, 0, 0));
        tbl[6]  = mk(1, 0, 0, 0, 0, 0, mkexp(0, 0, 0, 4, 0, 0, 0, 0, 0));
        tbl[7]  = mk(1, 0, 0, 0, 0, 0, mkexp(0, 0, 0, 5, 0, 0, 0, 0, 0));
        tbl[8]  = mk(1, 0, 0, 0, 0, 0, mkexp(0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl[9]  = mk(1, 0, 0, 1, 0, 0, mkexp(1, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl[10] = mk(1, 7, 1, 0, 0, 0, mkexp(1, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl[11] = mk(1, 2, 1, 1, 0, 0, mkexp(4, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl[12] = mk(0, 0, 0, 0, 1, 0, mkexp(4, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl[13] = mk(1, 1, 0, 0, 0, 1, mkexp(0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl[14] = mk(1, 5, 0, 0, 0, 0, mkexp(5, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl[15] = mk(1, 6, 1, 0, 0, 0, mkexp(11, 1, 0, 2, 0, 0, 0, 0, 0));
        tbl[16] = mk(0, 0, 0, 0, 0, 1, mkexp(0, 0, 0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].v, tbl[i].r, tbl[i].w, tbl[i].e, tbl[i].ni, tbl[i].ng);
            q.push_back(tbl[i].x);
            check($sformatf("vec%0d", i));
        end

        // Ten wickets close innings 1; BREAK ignores deliveries
        step(0, 0, 0, 0, 0, 1, "new_game");
        repeat (10) ev(0, 1, 0, "wkt");
        expect_now("all_out_break", mkexp(0, 10, 1, 4, 0, 1, 0, 0, 0));
        repeat (3) ev(4, 0, 0, "break_ignore");
        expect_now("break_hold", mkexp(0, 10, 1, 4, 0, 1, 0, 0, 0));
        step(0, 0, 0, 0, 1, 0, "next_inning");
        expect_now("inn2_start", mkexp(0, 0, 0, 0, 1, 0, 0, 0, 0));

        // Chase 151 with three wickets down
        innings1_150();
        repeat (3) ev(0, 1, 0, "inn2_wkt");
        repeat (25) ev(6, 0, 0, "inn2_six");
        ev(1, 0, 0, "inn2_win");
        expect_now("chase_win", mkexp(151, 3, 4, 5, 1, 0, 1, 1, 0));
        ev(4, 1, 0, "done_ignore");
        step(0, 0, 0, 0, 1, 0, "done_ni_ignore");
        expect_now("done_hold", mkexp(151, 3, 4, 5, 1, 0, 1, 1, 0));

        // Tie at 150
        innings1_150();
        repeat (25) ev(6, 0, 0, "inn2_six");
        repeat (10) ev(0, 1, 0, "inn2_wkt");
        expect_now("tie_result", mkexp(150, 10, 5, 5, 1, 0, 1, 0, 1));

        // All out at 120
        innings1_150();
        repeat (20) ev(6, 0, 0, "inn2_six");
        repeat (10) ev(0, 1, 0, "inn2_wkt");
        expect_now("loss_result", mkexp(120, 10, 5, 0, 1, 0, 1, 0, 0));

        // Win on the same ball as the tenth wicket
        innings1_150();
        repeat (9) ev(0, 1, 0, "inn2_wkt");
        repeat (25) ev(6, 0, 0, "inn2_six");
        ev(1, 1, 0, "win_on_limit");
        expect_now("win_precedence", mkexp(151, 10, 5, 5, 1, 0, 1, 1, 0));

        // Saturation, overs limit, then async reset mid-innings 2
        step(0, 0, 0, 0, 0, 1, "new_game");
        repeat (44) ev(6, 0, 0, "sat_six");
        expect_now("saturate", mkexp(255, 0, 7, 2, 0, 0, 0, 0, 0));
        repeat (76) ev(0, 0, 0, "dot");
        expect_now("overs_limit", mkexp(255, 0, 20, 0, 0, 1, 0, 0, 0));
        step(0, 0, 0, 0, 1, 0, "next_inning");
        repeat (3) ev(2, 0, 0, "inn2_run");
        reset_n = 1'b0;
        #1 expect_now("async_reset", '0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        ev(3, 0, 0, "post_reset_ball");
        expect_now("post_reset_first", mkexp(3, 0, 0, 1, 0, 0, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
